// File: rtl/dmadd_sequencer.sv
// Command sequencer for the MIN/MAX/MADD datapath: clears the datapath, streams
// load beats into it, runs it until it reports completion or times out, and returns the result.
module dmadd_sequencer #(
    parameter int unsigned TIMEOUT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_cnt,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [3:0] ld_index,
    input  logic [3:0] ld_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       busy,
    output logic       dm_rst_n,
    output logic [3:0] dm_index,
    output logic [3:0] dm_data,
    output logic [1:0] dm_insn,
    output logic       dm_load,
    output logic       dm_run,
    input  logic [7:0] dm_out,
    input  logic [3:0] dm_out_top
);

    localparam int unsigned RW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [RW-1:0] RUN_LAST = RW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_INIT,
        S_LOAD,
        S_RUN,
        S_RESULT
    } state_t;

    typedef enum logic [1:0] {
        OP_MIN  = 2'b00,
        OP_MAX  = 2'b01,
        OP_MADD = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    state_t        state, state_n;
    op_t           op_q;
    logic [3:0]    cnt_q;
    logic [3:0]    beat_q;
    logic [RW-1:0] run_q;
    logic [7:0]    res_data_q;
    logic          res_err_q;
    logic          run_last;

    assign run_last = (run_q == RUN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_MIN;
            cnt_q      <= '0;
            beat_q     <= '0;
            run_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= op_t'(cmd_op);
                        cnt_q  <= cmd_cnt;
                        beat_q <= '0;
                        run_q  <= '0;
                        if (op_t'(cmd_op) == OP_RSVD) begin
                            res_data_q <= '0;
                            res_err_q  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        beat_q <= beat_q + 4'd1;
                    end
                end
                S_RUN: begin
                    if (!run_last) begin
                        run_q <= run_q + RW'(1);
                    end
                    // Completion on the last allowed cycle still counts as a normal finish.
                    if (dm_out_top == 4'd0) begin
                        res_data_q <= dm_out;
                        res_err_q  <= 1'b0;
                    end else if (run_last) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_n = (op_t'(cmd_op) == OP_RSVD) ? S_RESULT : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (op_q != OP_MADD) begin
                    state_n = S_INIT;
                end else begin
                    state_n = (cnt_q == 4'd0) ? S_RUN : S_LOAD;
                end
            end
            S_INIT: begin
                state_n = (cnt_q == 4'd0) ? S_RUN : S_LOAD;
            end
            S_LOAD: begin
                if (ld_valid && (beat_q == cnt_q - 4'd1)) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if ((dm_out_top == 4'd0) || run_last) begin
                    state_n = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        ld_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        res_data  = res_data_q;
        res_err   = res_err_q;
        dm_rst_n  = 1'b1;
        dm_index  = '0;
        dm_data   = '0;
        dm_insn   = 2'b11;
        dm_load   = 1'b0;
        dm_run    = 1'b0;
        if (rst) begin
            dm_rst_n = 1'b0;
            res_data = '0;
            res_err  = 1'b0;
        end else begin
            busy = (state != S_IDLE);
            case (state)
                S_IDLE:  cmd_ready = 1'b1;
                S_CLEAR: dm_rst_n = 1'b0;
                S_INIT:  dm_insn = op_q;
                S_LOAD: begin
                    ld_ready = 1'b1;
                    dm_index = ld_index;
                    dm_data  = ld_data;
                    if (ld_valid) begin
                        dm_load = 1'b1;
                        dm_insn = op_q;
                    end
                end
                S_RUN: begin
                    dm_insn = op_q;
                    dm_run  = (dm_out_top != 4'd0);
                end
                S_RESULT: res_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dmadd_sequencer.md
DMADD_SEQUENCER -- requirements
Module: dmadd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 20, max RUN cycles before abort with error.
REQ-002 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-004 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-005 cmd_op  in  2  operation: 00 MIN, 01 MAX, 10 MADD, 11 reserved; cmd_cnt  in  4  number of load beats (0..15).
REQ-006 ld_valid  in  1 / ld_ready  out  1  load-beat handshake; ld_index  in  4  target entry; ld_data  in  4  MADD operand.
REQ-007 res_valid  out  1 / res_ready  in  1  result handshake; res_data  out  8  result; res_err  out  1  timeout or reserved op.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 Datapath-side ports: dm_rst_n  out  1, dm_index  out  4, dm_data  out  4, dm_insn  out  2, dm_load  out  1, dm_run  out  1.
REQ-010 Datapath-side inputs: dm_out  in  8  datapath result; dm_out_top  in  4  datapath step value, 0 = finished.

Function
REQ-011 States: IDLE, CLEAR, INIT, LOAD, RUN, RESULT; one-hot or binary encoding is free.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, latch cmd_op and cmd_cnt and go to CLEAR; for cmd_op=11, go directly to RESULT with res_err=1 and res_data=0.
REQ-013 CLEAR (1 cycle): dm_rst_n=0; then go to INIT for MIN/MAX, or to LOAD for MADD.
REQ-014 INIT (1 cycle): dm_load=0, dm_run=0, dm_insn=latched op; then go to LOAD.
REQ-015 LOAD: ld_ready=1, dm_load=ld_valid, dm_index=ld_index, dm_data=ld_data, dm_insn = op (MIN/MAX) or 10 (MADD).
REQ-016 LOAD: beat counter increments per accepted beat; go to RUN on the cycle after the cmd_cnt-th beat; if cmd_cnt=0, go to RUN immediately, with zero LOAD cycles of ld_ready.
REQ-017 LOAD with ld_valid=0: dm_load=0 and dm_run=0, and the datapath is driven with insn=11 (hold).
REQ-018 RUN: dm_run=1, dm_load=0, dm_insn=latched op, and the RUN cycle counter increments.
REQ-019 RUN exit, normal: on the first cycle dm_out_top==0, capture res_data=dm_out and res_err=0, deassert dm_run that cycle, and go to RESULT.
REQ-020 RUN exit, timeout: when the counter reaches TIMEOUT with dm_out_top still nonzero, capture res_data=0 and res_err=1, and go to RESULT.
REQ-021 RUN is not entered early: dm_out_top==0 during CLEAR/INIT/LOAD is ignored.
REQ-022 RESULT: res_valid=1 with res_data and res_err held stable until res_ready; on handshake, return to IDLE.
REQ-023 Handshakes: each ready depends only on state, never combinationally on the matching valid; cmd_ready=0 outside IDLE.
REQ-024 Default drive outside the states above: dm_load=0, dm_run=0, dm_insn=11, dm_index=0, dm_data=0, dm_rst_n=1.
REQ-025 Counters: beat counter 4 bit, RUN counter wide enough for TIMEOUT, no wrap; both clear on entry to CLEAR.
REQ-026 Latency from command accept to RUN: 2 cycles + beats for MIN/MAX, 1 cycle + beats for MADD.

Reset
REQ-027 rst=1 forces IDLE next edge from any state, discarding any in-flight command or result.
REQ-028 Outputs while rst=1 and after: cmd_ready=1 after reset; ld_ready=0, res_valid=0, res_data=0, res_err=0, busy=0.
REQ-029 dm_rst_n=0 while rst=1, so the datapath is cleared together with the sequencer.

Verification
REQ-030 MIN, cnt=2, beats index 9 and 3 -> res_data=3, res_err=0, one res_valid pulse.
REQ-031 MAX, cnt=2, beats index 3 and 9 -> res_data=9, res_err=0.
REQ-032 MIN, cnt=0 (empty memory) -> timeout after 20 RUN cycles, res_err=1, res_data=0.
REQ-033 op=11 -> RESULT within 1 cycle with res_err=1; dm_run and dm_load never asserted.
REQ-034 rst pulse mid-LOAD after 1 of 3 beats -> busy=0, dm_rst_n=0 during rst; a following MIN, cnt=1, index 7 -> res_data=7.
REQ-035 Hold res_ready=0 for 10 cycles -> res_valid and res_data stable, cmd_ready=0 throughout; accepted on the cycle res_ready rises.
